// File: rtl/stoch_pkg.sv
// Shared types and helpers for the stochastic-to-binary decode path.
package stoch_pkg;

    localparam int unsigned S2B_BIN_LEN = 4;

    typedef enum logic [1:0] {
        S2B_IDLE = 2'd0,
        S2B_RUN  = 2'd1,
        S2B_DONE = 2'd2
    } s2b_state_t;

    // One full period of a maximal-length LFSR of the given width.
    function automatic int unsigned win_len(input int unsigned bin_len);
        return (32'd1 << bin_len) - 32'd1;
    endfunction

endpackage

// File: rtl/s2b_window_cnt.sv
// Accepted-bit counter for one conversion window; flags the final bit of the window.
module s2b_window_cnt
    import stoch_pkg::*;
#(
    parameter int unsigned BIN_LEN = S2B_BIN_LEN,
    parameter int unsigned WIN_LEN = win_len(BIN_LEN)
) (
    input  logic clock,
    input  logic reset_n,
    input  logic enable,
    input  logic clear,
    input  logic inc,
    output logic last_bit_c
);

    logic [BIN_LEN-1:0] r_count;

    // Stops at WIN_LEN because the FSM leaves RUN on the last bit.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (enable) begin
            if (clear) begin
                r_count <= '0;
            end else if (inc) begin
                r_count <= r_count + BIN_LEN'(1);
            end
        end
    end

    assign last_bit_c = inc && (r_count == BIN_LEN'(WIN_LEN - 1));

endmodule

// File: rtl/stoch_to_bin.sv
// Stochastic-to-binary converter: accumulates a serial bitstream over one LFSR period
// in unipolar or bipolar encoding and hands the result out via valid/ready.
module stoch_to_bin
    import stoch_pkg::*;
#(
    parameter int unsigned BIN_LEN = S2B_BIN_LEN,
    parameter int unsigned WIN_LEN = win_len(BIN_LEN)
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               enable,
    input  logic               start,
    input  logic               bipolar,
    input  logic               bit_in,
    input  logic               bit_valid,
    output logic               busy,
    output logic [BIN_LEN:0]   out_val,
    output logic               out_valid,
    input  logic               out_ready
);

    localparam int unsigned ACC_W = BIN_LEN + 1;

    s2b_state_t         r_state;
    s2b_state_t         w_next_state;
    logic               r_busy;
    logic               r_out_valid;
    logic               r_bipolar;
    logic [ACC_W-1:0]   r_acc;
    logic [ACC_W-1:0]   r_out_val;
    logic [ACC_W-1:0]   w_delta;
    logic [ACC_W-1:0]   w_acc_sum;
    logic               w_clear;
    logic               w_inc;
    logic               w_last_bit;

    s2b_window_cnt #(
        .BIN_LEN (BIN_LEN),
        .WIN_LEN (WIN_LEN)
    ) u_window_cnt (
        .clock      (clock),
        .reset_n    (reset_n),
        .enable     (enable),
        .clear      (w_clear),
        .inc        (w_inc),
        .last_bit_c (w_last_bit)
    );

    // Bipolar maps a 0 to -1 so the sum is ones minus zeros.
    always_comb begin
        w_delta = '0;
        if (bit_in) begin
            w_delta = ACC_W'(1);
        end else if (r_bipolar) begin
            w_delta = '1;
        end
    end

    assign w_acc_sum = r_acc + w_delta;

    always_comb begin
        w_next_state = r_state;
        w_clear      = 1'b0;
        w_inc        = 1'b0;
        case (r_state)
            S2B_IDLE: begin
                if (start) begin
                    w_next_state = S2B_RUN;
                    w_clear      = 1'b1;
                end
            end
            S2B_RUN: begin
                if (bit_valid) begin
                    w_inc = 1'b1;
                    if (w_last_bit) begin
                        w_next_state = S2B_DONE;
                    end
                end
            end
            S2B_DONE: begin
                if (out_ready) begin
                    if (start) begin
                        w_next_state = S2B_RUN;
                        w_clear      = 1'b1;
                    end else begin
                        w_next_state = S2B_IDLE;
                    end
                end
            end
            default: begin
                w_next_state = S2B_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S2B_IDLE;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b0;
            r_bipolar   <= 1'b0;
            r_acc       <= '0;
            r_out_val   <= '0;
        end else if (enable) begin
            r_state     <= w_next_state;
            r_busy      <= (w_next_state == S2B_RUN);
            r_out_valid <= (w_next_state == S2B_DONE);
            if (w_clear) begin
                r_acc     <= '0;
                r_bipolar <= bipolar;
            end else if (w_inc) begin
                r_acc <= w_acc_sum;
            end
            if (w_inc && w_last_bit) begin
                r_out_val <= w_acc_sum;
            end
        end
    end

    assign busy      = r_busy;
    assign out_valid = r_out_valid;
    assign out_val   = r_out_val;

endmodule

// File: tb/tb_stoch_to_bin.sv
// Directed bench for stoch_to_bin at BIN_LEN=4 (15-bit windows, 5-bit result).
module tb_stoch_to_bin;

    logic       clock;
    logic       reset_n;
    logic       enable;
    logic       start;
    logic       bipolar;
    logic       bit_in;
    logic       bit_valid;
    logic       busy;
    logic [4:0] out_val;
    logic       out_valid;
    logic       out_ready;

    int errors = 0;
    int checks = 0;

    stoch_to_bin #(.BIN_LEN(4)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .enable    (enable),
        .start     (start),
        .bipolar   (bipolar),
        .bit_in    (bit_in),
        .bit_valid (bit_valid),
        .busy      (busy),
        .out_val   (out_val),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic begin_window(input logic bip);
        start     = 1'b1;
        bipolar   = bip;
        bit_valid = 1'b0;
        tick();
        start     = 1'b0;
        bipolar   = 1'b0;
    endtask

    task automatic feed(input logic b, input logic v);
        bit_in    = b;
        bit_valid = v;
        tick();
        bit_valid = 1'b0;
        bit_in    = 1'b0;
    endtask

    // 14 constant bits, then the 15th with checks on the completion edge.
    task automatic run_const(input string tag, input logic b, input logic [4:0] exp);
        for (int i = 0; i < 14; i++) feed(b, 1'b1);
        check({tag, "_valid_before_last"}, 32'(out_valid), 32'd0);
        feed(b, 1'b1);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_val"}, 32'(out_val), 32'(exp));
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic run_alternating(input string tag, input logic bip, input logic [4:0] exp);
        int nvalid;
        begin_window(bip);
        nvalid = 0;
        for (int c = 0; c < 40 && nvalid < 15; c++) begin
            if (c % 3 == 2) begin
                feed(1'b1, 1'b0);
            end else begin
                feed((nvalid % 2) == 0, 1'b1);
                nvalid++;
            end
        end
        check({tag, "_nvalid"}, 32'(nvalid), 32'd15);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_val"}, 32'(out_val), 32'(exp));
        release_result();
    endtask

    initial begin
        reset_n   = 1'b0;
        enable    = 1'b1;
        start     = 1'b0;
        bipolar   = 1'b0;
        bit_in    = 1'b0;
        bit_valid = 1'b0;
        out_ready = 1'b0;
        #3;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_val", 32'(out_val), 32'd0);
        tick();
        reset_n = 1'b1;
        tick();

        // Unipolar all ones.
        begin_window(1'b0);
        check("uni1_busy_start", 32'(busy), 32'd1);
        run_const("uni1", 1'b1, 5'd15);
        release_result();
        check("uni1_idle_valid", 32'(out_valid), 32'd0);
        check("uni1_val_kept", 32'(out_val), 32'd15);

        // Bipolar extremes.
        begin_window(1'b1);
        run_const("bip0", 1'b0, 5'b10001);
        release_result();
        begin_window(1'b1);
        run_const("bip1", 1'b1, 5'b01111);
        release_result();

        // Alternating stream with gaps.
        run_alternating("uni_alt", 1'b0, 5'd8);
        run_alternating("bip_alt", 1'b1, 5'd1);

        // Stall in DONE: 5 ones then 10 zeros, consumer not ready.
        begin_window(1'b0);
        for (int i = 0; i < 5; i++) feed(1'b1, 1'b1);
        for (int i = 0; i < 10; i++) feed(1'b0, 1'b1);
        check("hold_valid0", 32'(out_valid), 32'd1);
        check("hold_val0", 32'(out_val), 32'd5);
        for (int i = 0; i < 10; i++) begin
            start     = (i % 2) == 0;
            bit_valid = 1'b1;
            bit_in    = 1'b1;
            tick();
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_val", 32'(out_val), 32'd5);
        end
        bit_valid = 1'b0;
        bit_in    = 1'b0;
        start     = 1'b1;
        out_ready = 1'b1;
        tick();
        start     = 1'b0;
        out_ready = 1'b0;
        check("b2b_busy", 32'(busy), 32'd1);
        check("b2b_valid", 32'(out_valid), 32'd0);
        run_const("b2b", 1'b0, 5'd0);
        release_result();

        // Asynchronous reset mid-window.
        begin_window(1'b0);
        for (int i = 0; i < 7; i++) feed(1'b1, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_valid", 32'(out_valid), 32'd0);
        tick();
        reset_n = 1'b1;
        tick();
        begin_window(1'b0);
        run_const("arst_new", 1'b1, 5'd15);
        release_result();

        // Enable low for 3 cycles mid-window; those ones must not count.
        begin_window(1'b0);
        for (int i = 0; i < 6; i++) feed(1'b1, 1'b1);
        enable = 1'b0;
        for (int i = 0; i < 3; i++) feed(1'b1, 1'b1);
        check("en_busy_frozen", 32'(busy), 32'd1);
        enable = 1'b1;
        for (int i = 0; i < 8; i++) feed(1'b0, 1'b1);
        check("en_valid_before_last", 32'(out_valid), 32'd0);
        feed(1'b0, 1'b1);
        check("en_valid", 32'(out_valid), 32'd1);
        check("en_val", 32'(out_val), 32'd6);
        release_result();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
